// File: rtl/acc_mon_pkg.sv
// rtl/acc_mon_pkg.sv - shared widths, record type and pointer sizing for the window monitor
package acc_mon_pkg;

  localparam int SUM_W_DEF  = 8;
  localparam int WINDOW_DEF = 4;
  localparam int DEPTH_DEF  = 4;
  localparam int DROP_W_DEF = 8;

  // One extra pointer bit separates full from empty when the indices match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int PTR_W_DEF = ptr_w(DEPTH_DEF);

  typedef struct packed {
    logic [SUM_W_DEF-1:0] delta;
    logic                 over;
    logic [SUM_W_DEF-1:0] peak;
  } acc_rec_t;

endpackage

// File: rtl/acc_rec_fifo.sv
// rtl/acc_rec_fifo.sv - synchronous first-word fall-through FIFO over an arbitrary record type
module acc_rec_fifo
  import acc_mon_pkg::*;
#(
  parameter type rec_t = acc_rec_t,
  parameter int  DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_pop,
  input  rec_t i_data,
  output rec_t o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int AW    = PTR_W - 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  rec_t             r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop frees the head slot on the same edge, so a full FIFO can still accept.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/acc_window_monitor.sv
// rtl/acc_window_monitor.sv - per-window sum increment monitor with record FIFO; ACC_WIN_PEAK_EN adds peak tracking
module acc_window_monitor
  import acc_mon_pkg::*;
#(
  parameter int SUM_W  = SUM_W_DEF,
  parameter int WINDOW = WINDOW_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic [SUM_W-1:0]  sum,
  input  logic [SUM_W-1:0]  threshold,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_delta,
  output logic              out_over,
  output logic [SUM_W-1:0]  out_peak,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int                WIN_W    = $clog2(WINDOW);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  typedef struct packed {
    logic [SUM_W-1:0] delta;
    logic             over;
`ifdef ACC_WIN_PEAK_EN
    logic [SUM_W-1:0] peak;
`endif
  } rec_t;

  logic [WIN_W-1:0]  r_win_cnt;
  logic [SUM_W-1:0]  r_prev_sum;
  logic [DROP_W-1:0] r_drop_cnt;
  logic              w_capture;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [SUM_W-1:0]  w_delta;
  rec_t              w_rec;
  rec_t              w_head;

  // clear wins over capture; modulo subtraction absorbs accumulator wrap.
  assign w_capture = en && !clear && (r_win_cnt == WIN_LAST);
  assign w_delta   = sum - r_prev_sum;
  assign w_pop     = out_valid && out_ready;

`ifdef ACC_WIN_PEAK_EN
  logic [SUM_W-1:0] r_peak;
  logic [SUM_W-1:0] w_peak_next;

  assign w_peak_next = (sum > r_peak) ? sum : r_peak;

  always_ff @(posedge clk) begin
    if (!rst || clear || w_capture) begin
      r_peak <= '0;
    end else if (en) begin
      r_peak <= w_peak_next;
    end
  end
`endif

  always_comb begin
    w_rec       = '0;
    w_rec.delta = w_delta;
    w_rec.over  = (w_delta > threshold);
`ifdef ACC_WIN_PEAK_EN
    w_rec.peak  = w_peak_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_win_cnt  <= '0;
      r_prev_sum <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (clear) begin
        r_win_cnt  <= '0;
        r_prev_sum <= sum;
      end else if (en) begin
        r_win_cnt <= (r_win_cnt == WIN_LAST) ? '0 : r_win_cnt + 1'b1;
        if (w_capture) begin
          r_prev_sum <= sum;
        end
      end
      if (w_capture && w_full && !w_pop && (r_drop_cnt != DROP_MAX)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  acc_rec_fifo #(
    .rec_t (rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_capture),
    .i_pop   (w_pop),
    .i_data  (w_rec),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid = !w_empty;
  assign out_delta = w_head.delta;
  assign out_over  = w_head.over;
  assign drop_cnt  = r_drop_cnt;
`ifdef ACC_WIN_PEAK_EN
  assign out_peak  = w_head.peak;
`else
  assign out_peak  = '0;
`endif

endmodule

// File: tb/tb_acc_window_monitor.sv
// tb/tb_acc_window_monitor.sv - randomized self-checking bench for acc_window_monitor against a queue model
module tb_acc_window_monitor;

  localparam int WINDOW = 4;
  localparam int DEPTH  = 4;
`ifdef ACC_WIN_PEAK_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clear;
  logic [7:0] sum;
  logic [7:0] threshold;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_delta;
  logic       out_over;
  logic [7:0] out_peak;
  logic [7:0] drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int delta;
    bit over;
    int peak;
  } mrec_t;

  mrec_t m_q[$];
  int    m_cnt, m_prev, m_peak, m_drop;

  acc_window_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clear     (clear),
    .sum       (sum),
    .threshold (threshold),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_delta (out_delta),
    .out_over  (out_over),
    .out_peak  (out_peak),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural reference: count enabled cycles, take a sample every WINDOW, keep a bounded queue.
  task automatic model_edge();
    int    pk;
    bit    cap, pop, full;
    mrec_t r;
    if (!rst) begin
      m_cnt = 0; m_prev = 0; m_peak = 0; m_drop = 0;
      m_q.delete();
      return;
    end
    pop  = (m_q.size() > 0) && out_ready;
    full = (m_q.size() == DEPTH);
    cap  = 1'b0;
    if (clear) begin
      m_cnt = 0; m_prev = int'(sum); m_peak = 0;
    end else if (en) begin
      pk = (int'(sum) > m_peak) ? int'(sum) : m_peak;
      if (m_cnt == WINDOW - 1) begin
        cap     = 1'b1;
        r.delta = (int'(sum) - m_prev + 256) % 256;
        r.over  = r.delta > int'(threshold);
        r.peak  = PEAK_EN ? pk : 0;
        m_prev  = int'(sum);
        m_cnt   = 0;
        m_peak  = 0;
      end else begin
        m_cnt++;
        m_peak = pk;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (cap) begin
      if (full && !pop) begin
        if (m_drop < 255) m_drop++;
      end else begin
        m_q.push_back(r);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; clear = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en = 1'($urandom); clear = 1'($urandom); out_ready = 1'($urandom);
      sum = 8'($urandom); threshold = 8'($urandom);
      tick();
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    n_vec++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
    n_vec++; if (out_delta !== 8'd0) begin n_err++; $display("FAIL reset_delta got=%0d want=0", out_delta); end
    n_vec++; if (out_over !== 1'b0 || out_peak !== 8'd0) begin n_err++; $display("FAIL reset_over_peak got=%b/%0d want=0/0", out_over, out_peak); end
    rst = 1'b1; en = 1'b1; clear = 1'b0; out_ready = 1'b0; threshold = 8'd5;
    for (int i = 0; i < 3; i++) begin
      sum = 8'($urandom);
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_early_rec cyc=%0d got=%b want=0", i, out_valid); end
    end
    sum = 8'($urandom);
    tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL reset_first_rec got=%b want=1", out_valid); end
    n_vec++; if (out_delta !== 8'(sum)) begin n_err++; $display("FAIL reset_first_delta got=%0d want=%0d", out_delta, sum); end
  endtask

  task automatic test_ramp();
    int seen = 0;
    do_reset();
    en = 1'b1; out_ready = 1'b1; threshold = 8'd5;
    for (int i = 0; i < 9; i++) begin
      sum = 8'(i);
      tick();
      if (m_q.size() > 0) begin
        n_vec++; if (out_valid !== 1'b1 || out_delta !== 8'(m_q[0].delta) || out_over !== m_q[0].over || out_peak !== 8'(m_q[0].peak))
          begin n_err++; $display("FAIL ramp_head cyc=%0d got=%b/%0d/%b/%0d want=1/%0d/%b/%0d", i, out_valid, out_delta, out_over, out_peak, m_q[0].delta, m_q[0].over, m_q[0].peak); end
      end
      if (i == 3 || i == 7) begin
        n_vec++; if (out_delta !== ((seen == 0) ? 8'd3 : 8'd4) || out_over !== 1'b0)
          begin n_err++; $display("FAIL ramp_rec%0d got=%0d/%b want=%0d/0", seen, out_delta, out_over, (seen == 0) ? 3 : 4); end
        n_vec++; if (out_peak !== (PEAK_EN ? ((seen == 0) ? 8'd3 : 8'd7) : 8'd0))
          begin n_err++; $display("FAIL ramp_peak%0d got=%0d", seen, out_peak); end
        seen++;
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] thr_tab [3];
    bit         ovr_tab [3];
    thr_tab[0] = 8'd5;  ovr_tab[0] = 1'b1;
    thr_tab[1] = 8'd10; ovr_tab[1] = 1'b0;
    thr_tab[2] = 8'd9;  ovr_tab[2] = 1'b1;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      threshold = thr_tab[k];
      clear = 1'b1; en = 1'b1; sum = 8'd250;
      tick();
      clear = 1'b0; sum = 8'd4;
      for (int i = 0; i < 4; i++) tick();
      n_vec++; if (out_valid !== 1'b1 || out_delta !== 8'd10 || out_over !== ovr_tab[k])
        begin n_err++; $display("FAIL wrap thr=%0d got=%b/%0d/%b want=1/10/%b", thr_tab[k], out_valid, out_delta, out_over, ovr_tab[k]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1'b1; out_ready = 1'b0; threshold = 8'($urandom);
    for (int i = 0; i < 27; i++) begin
      sum = 8'($urandom);
      tick();
    end
    n_vec++; if (drop_cnt !== 8'd2) begin n_err++; $display("FAIL bp_drop got=%0d want=2", drop_cnt); end
    out_ready = 1'b1; sum = 8'($urandom);
    tick();
    n_vec++; if (drop_cnt !== 8'd2) begin n_err++; $display("FAIL bp_full_pushpop_drop got=%0d want=2", drop_cnt); end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (out_valid !== 1'b1 || m_q.size() == 0 || out_delta !== 8'(m_q[0].delta) || out_over !== m_q[0].over || out_peak !== 8'(m_q[0].peak))
        begin n_err++; $display("FAIL bp_order idx=%0d got=%b/%0d/%b/%0d", i, out_valid, out_delta, out_over, out_peak); end
      tick();
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained got=%b want=0", out_valid); end
  endtask

  task automatic test_en_clear();
    int         t = 0;
    logic [7:0] s;
    do_reset();
    out_ready = 1'b1; threshold = 8'd5;
    while (out_valid !== 1'b1 && t < 12) begin
      en = (t >= 2 && t < 5) ? 1'b0 : 1'b1;
      sum = 8'($urandom);
      tick();
      t++;
    end
    n_vec++; if (t !== 7) begin n_err++; $display("FAIL en_hold_latency got=%0d want=7", t); end
    en = 1'b1; clear = 1'b1; sum = 8'd100;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = 8'($urandom); sum = s;
      tick();
      if (i < 3) begin
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clear_early cyc=%0d got=%b want=0", i, out_valid); end
      end
    end
    n_vec++; if (out_valid !== 1'b1 || out_delta !== 8'(s - 8'd100))
      begin n_err++; $display("FAIL clear_delta got=%b/%0d want=1/%0d", out_valid, out_delta, 8'(s - 8'd100)); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    en = 1'b1; out_ready = 1'b0; threshold = 8'd5;
    for (int i = 0; i < 14; i++) begin
      sum = 8'($urandom);
      tick();
    end
    rst = 1'b0;
    tick();
    n_vec++; if (out_valid !== 1'b0 || drop_cnt !== 8'd0)
      begin n_err++; $display("FAIL midrst got=%b/%0d want=0/0", out_valid, drop_cnt); end
    rst = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sum = 8'($urandom);
      tick();
    end
    n_vec++; if (out_valid !== 1'b1 || out_delta !== sum)
      begin n_err++; $display("FAIL midrst_abs got=%b/%0d want=1/%0d", out_valid, out_delta, sum); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 9) < 8);
      clear     = ($urandom_range(0, 29) == 0);
      out_ready = ($urandom_range(0, 3) != 0) ^ (i >= 200 && i < 260);
      sum       = 8'($urandom);
      threshold = 8'($urandom_range(0, 255));
      tick();
      n_vec++; if (out_valid !== (m_q.size() > 0) || drop_cnt !== 8'(m_drop))
        begin n_err++; $display("FAIL rand_state cyc=%0d got=%b/%0d want=%b/%0d", i, out_valid, drop_cnt, m_q.size() > 0, m_drop); end
      if (m_q.size() > 0) begin
        n_vec++; if (out_delta !== 8'(m_q[0].delta) || out_over !== m_q[0].over || out_peak !== 8'(m_q[0].peak))
          begin n_err++; $display("FAIL rand_head cyc=%0d got=%0d/%b/%0d want=%0d/%b/%0d", i, out_delta, out_over, out_peak, m_q[0].delta, m_q[0].over, m_q[0].peak); end
      end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; clear = 1'b0; out_ready = 1'b0; sum = '0; threshold = 8'd5;
    #2;
    test_reset();
    test_ramp();
    test_wrap();
    test_backpressure();
    test_en_clear();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/acc_window_monitor.md
Name: acc_window_monitor

Overview:
- Downstream consumer of the accumulator's `sum` output.
- Samples `sum` once per fixed window of enabled cycles and computes the per-window increment (delta). Flags windows whose delta exceeds a programmable threshold.
- Queues {delta, over} records in a small FIFO with a valid/ready output for logging or a host reader.
- Sits between the accumulator and the capture/readout logic, on the same clock.

Parameters:
- SUM_W, 8, width of accumulator `sum` and of delta/threshold.
- WINDOW, 4, enabled cycles per sampling window; ≥2.
- DEPTH, 4, record FIFO entries; power of two, ≥2.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  design clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  window counter advances only when 1.
- clear  in  1  sync window restart; no FIFO flush.
- sum  in  SUM_W  accumulator output.
- threshold  in  SUM_W  unsigned over-threshold limit.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_delta  out  SUM_W  head record delta.
- out_over  out  1  head record over flag.
- out_peak  out  SUM_W  head record peak (see Optional Feature).
- drop_cnt  out  DROP_W  records lost to full FIFO, saturating.

Behaviour:
Reset (rst==0 at a clk edge):
- win_cnt=0, prev_sum=0, FIFO emptied.
- out_valid=0, out_delta=0, out_over=0, out_peak=0, drop_cnt=0.
- Reset has priority over every other input; a reset mid-window discards the partial window and any queued records.

Window counter (win_cnt, 0..WINDOW-1):
- Increments on each edge with en=1.
- Holds when en=0.
- Wraps to 0 after WINDOW-1.

Capture:
- Occurs on an edge with en=1 and win_cnt==WINDOW-1. The sampled value is `sum` at that edge.
- delta = sum - prev_sum, modulo 2^SUM_W; accumulator wrap yields the correct increment.
- over = (delta > threshold), unsigned compare.
- prev_sum <= sum.
- Record is pushed into the FIFO.

Clear:
- clear=1 (rst high): win_cnt <= 0, prev_sum <= sum, no capture that cycle. clear has priority over capture.
- FIFO contents and drop_cnt are unaffected.

FIFO:
- First-word fall-through: out_* shows the head combinationally from storage, out_valid = !empty.
- Latency: a record captured at edge N has out_valid=1 after edge N.
- Pop occurs when out_valid && out_ready.
- Push and pop on the same edge: both happen; occupancy is unchanged.
- Full with push and no pop: the record is dropped. drop_cnt increments, saturating at 2^DROP_W-1. Existing entries are unchanged.
- Full with push and pop on the same edge: the push is accepted, no drop.
- Empty: out_valid=0; out_delta/out_over/out_peak show stale storage and are don't-care.
- Pointers are log2(DEPTH)+1 bits; full/empty is decided by the MSB compare.

Optional Feature:
- Macro: ACC_WIN_PEAK_EN.
- With the macro defined:
  - A peak register tracks the maximum unsigned `sum` seen on enabled cycles in the current window, including the capture cycle.
  - Peak is stored in each record and appears on out_peak.
  - Peak is reset to 0 on rst, at window start after capture, and on clear.
- Without the macro: no peak register, no peak storage in the FIFO, out_peak tied to 0.

Decomposition:
- Package acc_mon_pkg:
  - acc_rec_t, a packed struct {delta, over, peak}.
  - Default width localparams.
  - clog2-based pointer width helper constant.
- One sub-module: acc_rec_fifo, a generic synchronous FWFT FIFO parameterised on the record type and DEPTH, with push/pop/full/empty.
- acc_window_monitor owns the counter, delta/compare and peak logic, and drop_cnt.

Test Plan:
Defaults: SUM_W=8, WINDOW=4, DEPTH=4, threshold=5 unless noted.
1. Reset: hold rst=0 for 2 cycles with random inputs -> out_valid=0, drop_cnt=0, out_delta=0. Release; no record before 4 enabled cycles.
2. Ramp: en=1, out_ready=1, sum=0,1,2,3,... per cycle -> first record delta=3, over=0. Next record delta=4, over=0. With ACC_WIN_PEAK_EN, peak=3 then 7.
3. Wrap: prev_sum=250, next sample sum=4 -> delta=10, over=1. threshold=10 -> over=0. threshold=9 -> over=1.
4. Backpressure: out_ready=0 for 6 windows -> 4 records held in order, drop_cnt=2. Then out_ready=1 on the cycle of a 7th capture while full -> push accepted, drop_cnt stays 2.
5. en/clear:
   - en low for 3 cycles mid-window -> capture delayed by exactly 3 cycles.
   - clear with sum=100 -> next record delta = sum_at_capture - 100, taken 4 enabled cycles later.
6. Mid-operation reset: reset with 3 records queued and win_cnt=2 -> FIFO empty and out_valid=0 next cycle. Next record's delta equals the absolute sampled sum (prev_sum=0).
